// File: rtl/fp_mul_norm_round.sv
// Final stage of the single-precision FP multiplier: aligns the significand product,
// rounds to nearest-even and packs the IEEE-754 word. Two-stage valid/ready pipeline.
module fp_mul_norm_round #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PROD_W = 2 * (DATA_W - 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_mant_overfl,
  input  logic [7:0]        in_exp_fin,
  input  logic [7:0]        in_mant_shift,
  input  logic              in_shift_left,
  input  logic [2:0]        in_prev_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_inexact,
  output logic              out_overflow,
  output logic              out_underflow
);

  localparam int unsigned F = DATA_W - 9;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: alignment
  logic [PROD_W-1:0] p0, p_al, rmask;
  logic              st0, st_al, big_shift;

  always_comb begin
    p0        = in_mant_overfl ? (in_prod >> 1) : in_prod;
    st0       = in_mant_overfl & in_prod[0];
    big_shift = 32'(in_mant_shift) >= PROD_W;
    rmask     = '0;
    p_al      = '0;
    st_al     = st0;
    if (in_shift_left) begin
      p_al = big_shift ? '0 : (p0 << in_mant_shift);
    end else if (big_shift) begin
      st_al = st0 | (|p0);
    end else begin
      rmask = ~({PROD_W{1'b1}} << in_mant_shift);
      p_al  = p0 >> in_mant_shift;
      st_al = st0 | (|(p0 & rmask));
    end
  end

  logic         s1_valid_q, s1_sign_q, s1_guard_q, s1_sticky_q;
  logic [7:0]   s1_exp_q;
  logic [F-1:0] s1_frac_q;
  logic [2:0]   s1_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s1_prev_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q   <= in_sign;
        s1_exp_q    <= in_exp_fin;
        s1_prev_q   <= in_prev_res;
        // Hidden bit sits at PROD_W-2 after alignment and is dropped here.
        s1_frac_q   <= p_al[PROD_W-3 -: F];
        s1_guard_q  <= p_al[PROD_W-3-F];
        s1_sticky_q <= st_al | (|p_al[PROD_W-4-F:0]);
      end
    end
  end

  // Stage 2: round to nearest-even and pack
  logic              round_up;
  logic [DATA_W-2:0] sum;
  logic [7:0]        e_rnd;
  logic [F-1:0]      f_rnd;
  logic [DATA_W-1:0] data_d;
  logic              inexact_d, overflow_d, underflow_d;

  always_comb begin
    round_up    = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
    sum         = {s1_exp_q, s1_frac_q} + (DATA_W-1)'(round_up);
    e_rnd       = sum[DATA_W-2 -: 8];
    f_rnd       = sum[F-1:0];
    inexact_d   = s1_guard_q | s1_sticky_q;
    overflow_d  = 1'b0;
    if (e_rnd == 8'hFF) begin
      f_rnd      = '0;
      overflow_d = 1'b1;
    end
    underflow_d = (e_rnd == 8'h00) & inexact_d;
    data_d      = {s1_sign_q, e_rnd, f_rnd};
    if (s1_prev_q != 3'b000) begin
      inexact_d   = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (s1_prev_q[2]) begin
        data_d = {s1_sign_q, 8'hFF, 1'b1, {(F-1){1'b0}}};
      end else if (s1_prev_q[1]) begin
        data_d = {s1_sign_q, 8'hFF, {F{1'b0}}};
      end else begin
        data_d = {s1_sign_q, {(DATA_W-1){1'b0}}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        out_data      <= data_d;
        out_inexact   <= inexact_d;
        out_overflow  <= overflow_d;
        out_underflow <= underflow_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed bench for fp_mul_norm_round: rounding, alignment, specials, backpressure, reset.
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_mant_overfl, in_shift_left;
  logic [47:0] in_prod;
  logic [7:0]  in_exp_fin, in_mant_shift;
  logic [2:0]  in_prev_res;
  logic        out_valid, out_ready, out_inexact, out_overflow, out_underflow;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] got[$];
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  fp_mul_norm_round #(.DATA_W(32), .PROD_W(48)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_prod       (in_prod),
    .in_mant_overfl(in_mant_overfl),
    .in_exp_fin    (in_exp_fin),
    .in_mant_shift (in_mant_shift),
    .in_shift_left (in_shift_left),
    .in_prev_res   (in_prev_res),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_inexact   (out_inexact),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  // Transfer happens at the next posedge; out_ready is stable from posedge+1.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 00000000", out_data);
    end
    checks++;
    if ({out_inexact, out_overflow, out_underflow} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000",
                         {out_inexact, out_overflow, out_underflow});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Send one beat with out_ready high; result must be valid exactly two edges later.
  task automatic single(input string name, input logic sign, input logic [47:0] prod,
                        input logic ovf, input logic [7:0] expf, input logic [7:0] sh,
                        input logic left, input logic [2:0] prev,
                        input logic [31:0] want, input logic [2:0] want_flags);
    out_ready      = 1'b1;
    in_valid       = 1'b1;
    in_sign        = sign;
    in_prod        = prod;
    in_mant_overfl = ovf;
    in_exp_fin     = expf;
    in_mant_shift  = sh;
    in_shift_left  = left;
    in_prev_res    = prev;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== want) begin
      errors++;
      $display("FAIL %s data: got valid=%b data=%h want valid=1 data=%h",
               name, out_valid, out_data, want);
    end
    checks++;
    if ({out_inexact, out_overflow, out_underflow} !== want_flags) begin
      errors++;
      $display("FAIL %s flags(ix,ov,uf): got %b want %b", name,
               {out_inexact, out_overflow, out_underflow}, want_flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    single("mul_1p5_sq", 1'b0, 48'h900000000000, 1'b1, 8'd128, 8'd0, 1'b0, 3'b000,
           32'h40100000, 3'b000);
    single("ovf_shift_sticky", 1'b0, 48'h900000000001, 1'b1, 8'd128, 8'd0, 1'b0, 3'b000,
           32'h40100000, 3'b100);
    single("left_shift2", 1'b0, 48'h100000000000, 1'b0, 8'd100, 8'd2, 1'b1, 3'b000,
           32'h32000000, 3'b000);
  endtask

  task automatic test_rounding();
    single("tie_even", 1'b0, 48'h400000400000, 1'b0, 8'd127, 8'd0, 1'b1, 3'b000,
           32'h3F800000, 3'b100);
    single("tie_odd", 1'b0, 48'h400000C00000, 1'b0, 8'd127, 8'd0, 1'b1, 3'b000,
           32'h3F800002, 3'b100);
    single("carry_254", 1'b0, 48'h7FFFFFC00000, 1'b0, 8'd254, 8'd0, 1'b1, 3'b000,
           32'h7F800000, 3'b110);
    single("carry_126", 1'b0, 48'h7FFFFFC00000, 1'b0, 8'd126, 8'd0, 1'b1, 3'b000,
           32'h3F800000, 3'b100);
  endtask

  task automatic test_denormal();
    single("denorm_rs3", 1'b0, 48'h400000000000, 1'b0, 8'd0, 8'd3, 1'b0, 3'b000,
           32'h00100000, 3'b000);
    single("denorm_rs1_sticky", 1'b0, 48'h400000000001, 1'b0, 8'd0, 8'd1, 1'b0, 3'b000,
           32'h00400000, 3'b101);
    single("denorm_rs60", 1'b0, 48'h400000000000, 1'b0, 8'd0, 8'd60, 1'b0, 3'b000,
           32'h00000000, 3'b101);
  endtask

  task automatic test_specials();
    single("nan", 1'b1, 48'h400000400000, 1'b0, 8'd127, 8'd0, 1'b1, 3'b100,
           32'hFFC00000, 3'b000);
    single("inf", 1'b0, 48'h400000400000, 1'b0, 8'd127, 8'd0, 1'b1, 3'b010,
           32'h7F800000, 3'b000);
    single("zero", 1'b1, 48'h400000400000, 1'b0, 8'd0, 8'd60, 1'b0, 3'b001,
           32'h80000000, 3'b000);
  endtask

  task automatic test_back_to_back();
    int          idx = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] want;
    got.delete();
    mon_en         = 1'b1;
    in_sign        = 1'b0;
    in_mant_overfl = 1'b0;
    in_mant_shift  = 8'd0;
    in_shift_left  = 1'b1;
    in_prev_res    = 3'b000;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (idx < 4) begin
        in_valid   = 1'b1;
        in_prod    = 48'h400000000000 | (48'(idx) << 23);
        in_exp_fin = 8'(120 + idx);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, in_ready);
        end
      end
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_data) begin
          errors++; $display("FAIL bp_hold c=%0d: got %h want %h", c, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mon_en    = 1'b0;
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d results want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      want = {1'b0, 8'(120 + i), 23'(i)};
      checks++;
      if (i >= got.size()) begin
        errors++; $display("FAIL bp_order[%0d]: got none want %h", i, want);
      end else if (got[i] !== want) begin
        errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], want);
      end
    end
  endtask

  task automatic test_reset_inflight();
    out_ready      = 1'b1;
    in_sign        = 1'b0;
    in_prod        = 48'h400000000000;
    in_mant_overfl = 1'b0;
    in_mant_shift  = 8'd0;
    in_shift_left  = 1'b1;
    in_prev_res    = 3'b000;
    in_exp_fin     = 8'd127;
    in_valid       = 1'b1;
    @(posedge clk); #1;
    in_exp_fin = 8'd128;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_inflight c=%0d: got valid=%b want 0", c, out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    out_ready      = 1'b1;
    in_sign        = 1'b0;
    in_prod        = '0;
    in_mant_overfl = 1'b0;
    in_exp_fin     = '0;
    in_mant_shift  = '0;
    in_shift_left  = 1'b0;
    in_prev_res    = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_denormal();
    test_specials();
    test_back_to_back();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_norm_round.md
Name: fp_mul_norm_round

Overview:
- Final stage of the single-precision FP multiplier datapath.
- Consumes the raw significand product plus the exponent and shift results of the exponent-formation stage (`exp_fin`, `mant_shift`).
- Aligns the product, rounds to nearest-even and packs the IEEE-754 word.
- Two-stage pipeline with valid/ready handshake.

Parameters:
- DATA_W, 32, float word width; fixed exponent width 8, fraction width F = DATA_W-9 = 23.
- PROD_W, 2*(DATA_W-8) = 48, significand product width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept input
- in_sign  in  1  result sign
- in_prod  in  PROD_W  unsigned 24x24 product; hidden bit at PROD_W-2, or PROD_W-1 on overflow
- in_mant_overfl  in  1  product bit PROD_W-1 set
- in_exp_fin  in  8  final biased exponent
- in_mant_shift  in  8  alignment shift amount
- in_shift_left  in  1  1 = left shift (normalisation), 0 = right shift (denormalisation)
- in_prev_res  in  3  special result: [2] NaN, [1] Inf, [0] zero
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  packed result
- out_inexact  out  1  guard or sticky nonzero
- out_overflow  out  1  finite operands produced Inf
- out_underflow  out  1  result exponent 0 and inexact

Behaviour:
- Reset: all valid bits 0; out_data, out_inexact, out_overflow, out_underflow 0. Reset mid-operation discards in-flight beats, with no output pulse.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - Both stages hold when advance = 0.
  - A beat is transferred on in_valid && in_ready.
  - Latency 2 cycles with no stall; throughput 1 per cycle; order preserved.
- Stage 1 (align):
  - If in_mant_overfl: p = in_prod >> 1, with the shifted-out bit going to sticky; otherwise p = in_prod.
  - Right shift: p >> in_mant_shift. Every shifted-out bit is ORed into sticky. A shift >= PROD_W gives p = 0 and sticky = |p.
  - Left shift: p << in_mant_shift, zero fill. A shift >= PROD_W gives 0.
  - Registered outputs: frac = p[45:23], guard = p[22], sticky |= |p[21:0], plus sign, exp_fin and prev_res.
- Stage 2 (round/pack):
  - round_up = guard & (sticky | frac[0]).
  - {e, f} = {exp_fin, frac} + round_up (31-bit add). A fraction carry increments the exponent; a denormal rounding to 2^-126 yields e = 1.
  - If e == 255: f forced to 0 and out_overflow = 1. This covers in_exp_fin == 255 (upstream saturation) and rounding carry from 254.
  - out_inexact = guard | sticky; out_underflow = (e == 0) & out_inexact.
- Special priority, evaluated in stage 2:
  - NaN: {sign, 8'hFF, 23'h400000}.
  - Then Inf: {sign, 8'hFF, 0}.
  - Then zero: {sign, 0, 0}.
  - Then the rounded result.
  - On any special result all three flags are 0.
- out_data and flags change only when advance = 1. They are held stable while out_valid && !out_ready.
- Simultaneous stall release and new input: the beat is accepted in the same cycle the output is consumed, with no bubble.

Test Plan:
1. 1.5*1.5: prod=0x900000000000, overfl=1, exp_fin=128, shift 0 -> out_data=0x40100000 two cycles after acceptance, all flags 0.
2. Tie to even:
   - frac lsb 0, guard 1, sticky 0, exp_fin=127 -> no increment, inexact=1.
   - Same with frac lsb 1 -> fraction +1.
3. Rounding carry: frac=0x7FFFFF, guard=1, exp_fin=254 -> out_data=0x7F800000, overflow=1. Same with exp_fin=126 -> 0x3F800000.
4. Denormal: exp_fin=0, right shift 3, prod=0x400000000000 (1.0) -> out_data=0x00100000, underflow=0. Shift 60 with nonzero prod -> 0x00000000, inexact=1, underflow=1.
5. Backpressure: 4 back-to-back beats, out_ready low cycles 3-5 -> in_ready low while stalled, out_data held, all 4 results emerge in order, none lost or duplicated.
6. Specials and reset:
   - prev_res=100, sign 1 -> 0xFFC00000; prev_res=010 -> 0x7F800000; prev_res=001, sign 1 -> 0x80000000.
   - rst asserted with 2 beats in flight -> out_valid=0 next cycle, no result emitted.
